// File: rtl/ibex_csr_shadow_bank.sv
// CSR bank with an optional inverted shadow copy per register and an optional
// two-phase update protocol (a write commits only when repeated identically).
//
// state  | meaning
// IDLE   | no write pending
// STAGED | first write latched, waiting for an identical confirming write
module ibex_csr_shadow_bank #(
   parameter int unsigned      Width      = 32,
   parameter int unsigned      NumRegs    = 4,
   parameter logic [Width-1:0] ResetValue = '0,
   parameter bit               ShadowCopy = 1'b1,
   parameter bit               TwoPhase   = 1'b1,
   localparam int unsigned     AW         = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [Width-1:0] rd_data_o,
   output logic             rd_error_o,
   output logic             staged_o,
   output logic             update_err_o,
   output logic             err_sticky_o
);

   typedef enum logic {IDLE = 1'b0, STAGED = 1'b1} state_e;

   state_e                        state_q, state_d;
   logic [AW-1:0]                 staged_addr_q, staged_addr_d;
   logic [Width-1:0]              staged_data_q, staged_data_d;
   logic [NumRegs-1:0][Width-1:0] primary_q;
   logic [NumRegs-1:0][Width-1:0] shadow_q;
   logic [NumRegs-1:0]            mismatch;
   logic                          wr_valid, rd_valid;
   logic                          commit;
   logic                          update_err_d, update_err_q;
   logic                          err_sticky_q;

   assign wr_valid = 32'(wr_addr_i) < NumRegs;
   assign rd_valid = 32'(rd_addr_i) < NumRegs;

   // Without a shadow copy there is nothing to compare, so every error source stays 0.
   for (genvar g = 0; g < NumRegs; g++) begin : g_chk
      assign mismatch[g] = ShadowCopy && (primary_q[g] != ~shadow_q[g]);
   end

   always_comb begin
      state_d       = state_q;
      staged_addr_d = staged_addr_q;
      staged_data_d = staged_data_q;
      commit        = 1'b0;
      update_err_d  = 1'b0;
      if (wr_en_i && wr_valid) begin
         if (!TwoPhase) begin
            commit = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  state_d       = STAGED;
                  staged_addr_d = wr_addr_i;
                  staged_data_d = wr_data_i;
               end
               STAGED: begin
                  state_d = IDLE;
                  if (wr_addr_i == staged_addr_q && wr_data_i == staged_data_q) begin
                     commit = 1'b1;
                  end else begin
                     update_err_d = ShadowCopy;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         staged_addr_q <= '0;
         staged_data_q <= '0;
         primary_q     <= {NumRegs{ResetValue}};
         shadow_q      <= {NumRegs{~ResetValue}};
         update_err_q  <= 1'b0;
         err_sticky_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         staged_addr_q <= staged_addr_d;
         staged_data_q <= staged_data_d;
         update_err_q  <= update_err_d;
         err_sticky_q  <= err_sticky_q | (|mismatch);
         if (commit) begin
            primary_q[wr_addr_i] <= wr_data_i;
            shadow_q[wr_addr_i]  <= ~wr_data_i;
         end
      end
   end

   // Reads see the registered value only; a same-cycle write is not bypassed.
   assign rd_data_o    = rd_valid ? primary_q[rd_addr_i] : '0;
   assign rd_error_o   = rd_valid & mismatch[rd_addr_i];
   assign staged_o     = (state_q == STAGED);
   assign update_err_o = update_err_q;
   assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_ibex_csr_shadow_bank.sv
// Bench for ibex_csr_shadow_bank: three configurations driven in parallel and
// checked every cycle against an array-based model of the register bank.
module tb_ibex_csr_shadow_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_addr;

   logic [31:0] rd_data [3];
   logic        rd_error [3];
   logic        staged [3];
   logic        uerr [3];
   logic        sticky [3];

   int total = 0;
   int bad   = 0;

   // configuration of each instance
   int unsigned nr [3] = '{4, 4, 3};
   bit          tp [3] = '{1'b0, 1'b1, 1'b1};
   logic [31:0] rv [3] = '{32'h0, 32'h0, 32'hC0DE0001};

   // model state
   logic [31:0] m_mem [3][4];
   bit          m_corrupt [3][4];
   bit          m_staged [3];
   logic [1:0]  m_sa [3];
   logic [31:0] m_sd [3];
   bit          m_uerr [3];
   bit          m_sticky [3];
   bit          started = 1'b0;

   logic [3:0][31:0] fv;

   always #5 clk = ~clk;

   ibex_csr_shadow_bank #(.NumRegs(4), .TwoPhase(1'b0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]),
      .rd_error_o(rd_error[0]), .staged_o(staged[0]), .update_err_o(uerr[0]),
      .err_sticky_o(sticky[0]));

   ibex_csr_shadow_bank #(.NumRegs(4), .TwoPhase(1'b1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]),
      .rd_error_o(rd_error[1]), .staged_o(staged[1]), .update_err_o(uerr[1]),
      .err_sticky_o(sticky[1]));

   ibex_csr_shadow_bank #(.NumRegs(3), .TwoPhase(1'b1), .ResetValue(32'hC0DE0001)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]),
      .rd_error_o(rd_error[2]), .staged_o(staged[2]), .update_err_o(uerr[2]),
      .err_sticky_o(sticky[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic commit(input int k, input logic [1:0] a, input logic [31:0] d);
      m_mem[k][a]     = d;
      m_corrupt[k][a] = 1'b0;
   endtask

   task automatic model_step();
      bit any;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
               m_mem[k][i]     = rv[k];
               m_corrupt[k][i] = 1'b0;
            end
            m_staged[k] = 1'b0;
            m_uerr[k]   = 1'b0;
            m_sticky[k] = 1'b0;
            m_sa[k]     = '0;
            m_sd[k]     = '0;
         end else begin
            any = 1'b0;
            for (int i = 0; i < int'(nr[k]); i++) any |= m_corrupt[k][i];
            m_sticky[k] |= any;
            m_uerr[k] = 1'b0;
            if (wr_en && 32'(wr_addr) < nr[k]) begin
               if (!tp[k]) begin
                  commit(k, wr_addr, wr_data);
               end else if (!m_staged[k]) begin
                  m_staged[k] = 1'b1;
                  m_sa[k]     = wr_addr;
                  m_sd[k]     = wr_data;
               end else begin
                  m_staged[k] = 1'b0;
                  if (wr_addr == m_sa[k] && wr_data == m_sd[k]) commit(k, wr_addr, wr_data);
                  else m_uerr[k] = 1'b1;
               end
            end
         end
      end
      if (!rst_n) started = 1'b1;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_data[%0d]", k), rd_data[k],
                (32'(rd_addr) < nr[k]) ? m_mem[k][rd_addr] : 32'h0);
            chk($sformatf("rd_error[%0d]", k), 32'(rd_error[k]),
                32'((32'(rd_addr) < nr[k]) && m_corrupt[k][rd_addr]));
            chk($sformatf("staged[%0d]", k), 32'(staged[k]), 32'(m_staged[k]));
            chk($sformatf("update_err[%0d]", k), 32'(uerr[k]), 32'(m_uerr[k]));
            chk($sformatf("err_sticky[%0d]", k), 32'(sticky[k]), 32'(m_sticky[k]));
         end
      end
   end

   task automatic put(input logic en, input logic [1:0] a, input logic [31:0] d,
                      input logic [1:0] ra);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
      rd_addr = ra;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      put(1'b0, 2'd0, 32'h0, 2'd0);
      repeat (2) @(negedge clk);
      chk("reset_rd0", rd_data[0], 32'h0);
      chk("reset_rd2", rd_data[2], 32'hC0DE0001);
      chk("reset_staged1", 32'(staged[1]), 32'h0);
      chk("reset_sticky1", 32'(sticky[1]), 32'h0);

      // two identical writes commit in the two-phase instances
      rst_n = 1'b1;
      put(1'b1, 2'd1, 32'h02020202, 2'd1);
      @(negedge clk);
      chk("tp0_single_write", rd_data[0], 32'h02020202);
      chk("tp1_staged_first", 32'(staged[1]), 32'h1);
      chk("tp1_not_committed", rd_data[1], 32'h0);
      @(negedge clk);
      chk("tp1_committed", rd_data[1], 32'h02020202);
      chk("tp1_staged_cleared", 32'(staged[1]), 32'h0);

      put(1'b1, 2'd2, 32'h01010101, 2'd2);
      @(negedge clk);
      chk("tp0_idx2", rd_data[0], 32'h01010101);
      chk("tp0_idx2_err", 32'(rd_error[0]), 32'h0);
      @(negedge clk);

      // mismatched second write
      put(1'b1, 2'd0, 32'hAAAAAAAA, 2'd0);
      @(negedge clk);
      put(1'b1, 2'd0, 32'h55555555, 2'd0);
      @(negedge clk);
      chk("mismatch_uerr", 32'(uerr[1]), 32'h1);
      chk("mismatch_no_commit", rd_data[1], 32'h0);
      chk("mismatch_idle", 32'(staged[1]), 32'h0);
      put(1'b0, 2'd0, 32'h0, 2'd0);
      @(negedge clk);
      chk("mismatch_pulse_end", 32'(uerr[1]), 32'h0);

      // reset beats a matching second-phase write
      put(1'b1, 2'd3, 32'h12345678, 2'd3);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_prio_rd", rd_data[1], 32'h0);
      chk("rst_prio_staged", 32'(staged[1]), 32'h0);
      rst_n = 1'b1;

      // out-of-range index on the 3-entry instance
      put(1'b1, 2'd3, 32'hDEADBEEF, 2'd3);
      @(negedge clk);
      chk("oor_not_staged", 32'(staged[2]), 32'h0);
      @(negedge clk);
      chk("oor_rd", rd_data[2], 32'h0);
      chk("oor_err", 32'(rd_error[2]), 32'h0);
      chk("oor_uerr", 32'(uerr[2]), 32'h0);
      chk("inrange_idx3", rd_data[1], 32'hDEADBEEF);

      // corrupt the shadow of idx 3
      put(1'b0, 2'd0, 32'h0, 2'd3);
      for (int i = 0; i < 4; i++) fv[i] = (i == 3) ? m_mem[1][i] : ~m_mem[1][i];
      force dut1.shadow_q = fv;
      m_corrupt[1][3] = 1'b1;
      #1;
      chk("corrupt_rd_error", 32'(rd_error[1]), 32'h1);
      chk("corrupt_sticky_pre", 32'(sticky[1]), 32'h0);
      @(negedge clk);
      chk("corrupt_sticky_set", 32'(sticky[1]), 32'h1);
      put(1'b0, 2'd0, 32'h0, 2'd0);
      repeat (2) @(negedge clk);
      chk("corrupt_sticky_held", 32'(sticky[1]), 32'h1);
      chk("corrupt_other_idx_ok", 32'(rd_error[1]), 32'h0);
      release dut1.shadow_q;
      rst_n = 1'b0;
      @(negedge clk);
      chk("corrupt_sticky_reset", 32'(sticky[1]), 32'h0);
      rst_n = 1'b1;

      // randomized traffic; repeats make confirming writes likely
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 99) != 0);
         wr_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            wr_addr = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
               0:       wr_data = 32'hAAAAAAAA;
               1:       wr_data = 32'h55555555;
               2:       wr_data = 32'h0;
               default: wr_data = $urandom;
            endcase
         end
         rd_addr = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
